// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its controller.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic              write;
        mem_size_t         size;
        logic              is_signed;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    // Little-endian byte enables for an access of the given size at a byte offset.
    function automatic logic [BE_W-1:0] lane_be_f(mem_size_t size, logic [1:0] offset);
        logic [BE_W-1:0] be;
        be = '0;
        case (size)
            MEM_BYTE: be = 4'b0001 << offset;
            MEM_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            MEM_WORD: be = 4'b1111;
            default:  be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: replicates store data into lanes and extracts/extends load data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  mem_size_t         size,
    input  logic [1:0]        offset,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [DATA_W-1:0] wlanes_c,
    output logic [DATA_W-1:0] rdata_c
);

    logic [15:0] shifted;

    always_comb begin
        wlanes_c = wdata;
        rdata_c  = rword;
        shifted  = 16'(rword >> {offset, 3'b000});
        case (size)
            MEM_BYTE: begin
                wlanes_c = {4{wdata[7:0]}};
                rdata_c  = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            end
            MEM_HALF: begin
                wlanes_c = {2{wdata[15:0]}};
                rdata_c  = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed latency, byte-lane steering and error checks.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_memReq,
    input  logic              i_memWrite,
    input  logic [1:0]        i_memSize,
    input  logic              i_isLoadSigned,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ready,
    output logic              o_valid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    dmem_state_t       state;
    dmem_state_t       state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    dmem_req_t         req_q;

    logic [IDX_W-1:0]  idx;
    logic              err_c;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] rword;
    logic [DATA_W-1:0] wlanes;
    logic [DATA_W-1:0] rdata_c;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (i_memReq) begin
                    if (LATENCY > 1) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request is captured only when accepted in IDLE; inputs are don't-care otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else if (state == IDLE && i_memReq) begin
            req_q <= '{write:     i_memWrite,
                       size:      mem_size_t'(i_memSize),
                       is_signed: i_isLoadSigned,
                       addr:      i_addr,
                       wdata:     i_wdata};
        end
    end

    assign idx   = req_q.addr[IDX_W+1:2];
    assign be    = lane_be_f(req_q.size, req_q.addr[1:0]);
    assign rword = mem[idx];

    always_comb begin
        err_c = 1'b0;
        case (req_q.size)
            MEM_HALF: err_c = req_q.addr[0];
            MEM_WORD: err_c = (req_q.addr[1:0] != 2'b00);
            MEM_RSVD: err_c = 1'b1;
            default:  err_c = 1'b0;
        endcase
        if ({2'b00, req_q.addr[DATA_W-1:2]} >= DATA_W'(DEPTH)) begin
            err_c = 1'b1;
        end
    end

    dmem_lane_align u_align (
        .size      (req_q.size),
        .offset    (req_q.addr[1:0]),
        .is_signed (req_q.is_signed),
        .wdata     (req_q.wdata),
        .rword     (rword),
        .wlanes_c  (wlanes),
        .rdata_c   (rdata_c)
    );

    // Store commits on the edge closing RESP; a reset at that edge drops it.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && req_q.write && !err_c) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == RESP);
    assign o_err   = (state == RESP) && err_c;
    assign o_rdata = (state == RESP && !err_c && !req_q.write) ? rdata_c : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder (LATENCY=2 and LATENCY=1 builds) against a byte-array model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr, sgn, sel;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        rdy0, vld0, er0, rdy1, vld1, er1;
    logic [31:0] rd0, rd1;
    logic        rdy, vld, er;
    logic [31:0] rd;

    logic [7:0]  ref_mem [2][4*DEPTH];
    int          lat_of [2] = '{2, 1};
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .i_memReq(req && !sel), .i_memWrite(wr), .i_memSize(size),
        .i_isLoadSigned(sgn), .i_addr(addr), .i_wdata(wdata),
        .o_ready(rdy0), .o_valid(vld0), .o_err(er0), .o_rdata(rd0)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_memReq(req && sel), .i_memWrite(wr), .i_memSize(size),
        .i_isLoadSigned(sgn), .i_addr(addr), .i_wdata(wdata),
        .o_ready(rdy1), .o_valid(vld1), .o_err(er1), .o_rdata(rd1)
    );

    assign rdy = sel ? rdy1 : rdy0;
    assign vld = sel ? vld1 : vld0;
    assign er  = sel ? er1  : er0;
    assign rd  = sel ? rd1  : rd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Behavioural model: little-endian byte array, errors leave it untouched.
    function automatic void model(input int d, input logic w, input logic [1:0] sz, input logic s,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic e, output logic [31:0] r);
        int nbytes;
        e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (a / 4 >= DEPTH);
        r = '0;
        if (e) return;
        nbytes = 1 << sz;
        if (w) begin
            for (int i = 0; i < nbytes; i++) ref_mem[d][a + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nbytes; i++) r[8*i +: 8] = ref_mem[d][a + i];
            if (s && nbytes < 4 && r[8*nbytes-1]) r = r | ~((32'd1 << (8*nbytes)) - 32'd1);
        end
    endfunction

    task automatic access(input logic w, input logic [1:0] sz, input logic s, input logic [31:0] a,
                          input logic [31:0] wd, input string tag,
                          output logic [31:0] got, output logic got_err);
        logic        e;
        logic [31:0] r;
        int          cyc, low, d;
        d   = sel ? 1 : 0;
        cyc = 0;
        while (!rdy && cyc < 50) begin @(negedge clk); cyc++; end
        check({tag, "_rdy_in"}, 32'(rdy), 32'd1);
        req = 1'b1; wr = w; size = sz; sgn = s; addr = a; wdata = wd;
        model(d, w, sz, s, a, wd, e, r);
        @(posedge clk); #1;
        req = 1'b0; wr = 1'($urandom); size = 2'($urandom); sgn = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        cyc = 0; low = 0; got = '0; got_err = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!rdy) low++;
            if (vld) begin got = rd; got_err = er; break; end
        end
        check({tag, "_lat"},   32'(cyc), 32'(lat_of[d]));
        check({tag, "_nrdy"},  32'(low), 32'(lat_of[d]));
        check({tag, "_err"},   32'(got_err), 32'(e));
        check({tag, "_rdata"}, got, r);
        @(negedge clk);
        check({tag, "_post"},  {30'd0, rdy, vld}, 32'b10);
    endtask

    // Request held high every cycle: only cycles that show ready get serviced.
    task automatic stream(input int ncyc);
        logic [31:0] q[$];
        logic        e;
        logic [31:0] r;
        int          d, last, nextra, lat;
        d = sel ? 1 : 0; lat = lat_of[d]; last = -1; nextra = 0;
        for (int c = 0; c < ncyc + 30; c++) begin
            if (vld) begin
                if (q.size() == 0) nextra++;
                else check("strm_data", rd, q.pop_front());
                if (last >= 0) check("strm_gap", 32'(c - last), 32'(lat + 1));
                last = c;
            end
            if (c < ncyc) begin
                req = 1'b1; wr = 1'b0; size = 2'd2; sgn = 1'($urandom);
                addr = 32'($urandom_range(0, 31)) << 2;
                if (rdy) begin
                    model(d, 1'b0, 2'd2, sgn, addr, 32'd0, e, r);
                    q.push_back(r);
                end
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
        end
        check("strm_extra", 32'(nextra), 32'd0);
        check("strm_drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, a;
        logic        ge, w;
        logic [1:0]  sz;
        rst = 1'b1; req = 1'b0; sel = 1'b0; wr = 1'b0; size = 2'd0; sgn = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_l2", {rdy0, vld0, er0, |rd0}, 4'b1000);
        check("rst_l1", {rdy1, vld1, er1, |rd1}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            sel = 1'(d);
            for (int i = 0; i < 32; i++) access(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "fill", got, ge);
        end

        sel = 1'b0;
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "st_w10", got, ge);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_w10", got, ge);
        check("tp_w10", got, 32'hDEADBEEF);
        access(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000007F, "st_b13", got, ge);
        access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "ld_bs13", got, ge);
        check("tp_bs13", got, 32'h0000007F);
        access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "ld_hs12", got, ge);
        check("tp_hs12", got, 32'h00007FAD);
        access(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, "ld_bs10", got, ge);
        check("tp_bs10", got, 32'hFFFFFFEF);
        access(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, "ld_bu10", got, ge);
        check("tp_bu10", got, 32'h000000EF);

        access(1'b1, 2'd1, 1'b0, 32'h11, 32'h0000AAAA, "e_h11", got, ge);
        check("tp_e_h11", {31'd0, ge}, 32'd1);
        access(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, "e_w12", got, ge);
        check("tp_e_w12", {got[30:0], ge}, 32'd1);
        access(1'b1, 2'd3, 1'b0, 32'h10, 32'h55555555, "e_rsvd", got, ge);
        check("tp_e_rsvd", {31'd0, ge}, 32'd1);
        access(1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h66666666, "e_oor", got, ge);
        check("tp_e_oor", {31'd0, ge}, 32'd1);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "unch10", got, ge);
        check("tp_unch10", got, 32'h7FADBEEF);
        access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "unch00", got, ge);

        for (int d = 0; d < 2; d++) begin
            sel = 1'(d);
            for (int i = 0; i < 150; i++) begin
                case ($urandom_range(0, 9))
                    0:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
                    1:       a = $urandom;
                    default: a = 32'($urandom_range(0, 127));
                endcase
                w  = 1'($urandom);
                sz = 2'($urandom);
                access(w, sz, 1'($urandom), a, $urandom, "rnd", got, ge);
            end
            stream(40);
        end

        sel = 1'b0;
        access(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, "pre20", got, ge);
        req = 1'b1; wr = 1'b1; size = 2'd2; sgn = 1'b0; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        check("rst_wait_rdy", 32'(rdy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid", {rdy, vld, er, |rd}, 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "post_rst20", got, ge);
        check("tp_rst20", got, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
